div_iter_radix2: RTL and testbench

- Iterative radix-2 restoring integer divider for the M-extension DIV/DIVU/REM/REMU and, when WIDTH=64, DIVW/DIVUW/REMW/REMUW.
- Where the ALU produces single-cycle add, subtract and shift results, this block consumes operands over many cycles using one subtract-and-shift step per cycle.
- It sits beside the ALU in the execute stage.
- The pipeline holds the instruction while Busy is high and captures Result on the Done pulse.

---
 rtl/div_iter_radix2.sv | 180 ++++++++++++++++++
 tb/tb_div_iter_radix2.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_iter_radix2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | div_iter_radix2                                                            |
// | Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU and word forms.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module div_iter_radix2 #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             Start,
    input  logic             Flush,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       Funct3,
    input  logic             W64,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result
);

    localparam int          CW     = $clog2(WIDTH);
    localparam bit          HAS_W  = (WIDTH == 64);
    localparam logic [31:0] MIN32  = 32'h8000_0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             sel_rem_q, sel_rem_d;
    logic             word_q, word_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             word_in, sgn_in, sa, sb, div_zero, ovf;
    logic [WIDTH-1:0] a_eff, b_eff, a_mag, b_mag, min_val;
    logic [WIDTH:0]   shifted, trial;
    logic [WIDTH-1:0] q_fix, r_fix, sel_fix, fix_res;

    // Operand conditioning happens on the live inputs so the accept cycle can decide special cases.
    assign word_in  = W64 && HAS_W;
    assign sgn_in   = ~Funct3[0];
    assign a_eff    = word_in ? (sgn_in ? WIDTH'($signed(A[31:0])) : WIDTH'(A[31:0])) : A;
    assign b_eff    = word_in ? (sgn_in ? WIDTH'($signed(B[31:0])) : WIDTH'(B[31:0])) : B;
    assign sa       = sgn_in & a_eff[WIDTH-1];
    assign sb       = sgn_in & b_eff[WIDTH-1];
    assign a_mag    = sa ? -a_eff : a_eff;
    assign b_mag    = sb ? -b_eff : b_eff;
    assign min_val  = word_in ? WIDTH'($signed(MIN32)) : {1'b1, {(WIDTH-1){1'b0}}};
    assign div_zero = (b_eff == '0);
    assign ovf      = sgn_in && (a_eff == min_val) && (b_eff == '1);

    assign shifted  = {rem_q, quo_q[WIDTH-1]};
    assign trial    = shifted - {1'b0, dvs_q};

    assign q_fix    = qneg_q ? -quo_q : quo_q;
    assign r_fix    = rneg_q ? -rem_q : rem_q;
    assign sel_fix  = sel_rem_q ? r_fix : q_fix;
    assign fix_res  = word_q ? WIDTH'($signed(sel_fix[31:0])) : sel_fix;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        sel_rem_d = sel_rem_q;
        word_d    = word_q;
        result_d  = result_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (Start && !Flush) begin
                    word_d    = word_in;
                    sel_rem_d = Funct3[1];
                    dvs_d     = b_mag;
                    qneg_d    = 1'b0;
                    rneg_d    = 1'b0;
                    cnt_d     = '0;
                    state_d   = S_FIX;
                    if (div_zero) begin
                        quo_d = '1;
                        rem_d = a_eff;
                    end else if (ovf) begin
                        quo_d = a_eff;
                        rem_d = '0;
                    end else begin
                        // Left-align word dividends so the top-bit shift-out works for any N.
                        quo_d   = word_in ? (a_mag << (WIDTH - 32)) : a_mag;
                        rem_d   = '0;
                        qneg_d  = sa ^ sb;
                        rneg_d  = sa;
                        cnt_d   = word_in ? CW'(31) : CW'(WIDTH - 1);
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (Flush) begin
                    state_d = S_IDLE;
                end else begin
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    if (!trial[WIDTH]) begin
                        rem_d    = trial[WIDTH-1:0];
                        quo_d[0] = 1'b1;
                    end else begin
                        rem_d = shifted[WIDTH-1:0];
                    end
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                if (Flush) begin
                    state_d = S_IDLE;
                end else begin
                    result_d = fix_res;
                    state_d  = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_BUSY) || (state_d == S_FIX);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            sel_rem_q <= 1'b0;
            word_q    <= 1'b0;
            result_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
            sel_rem_q <= sel_rem_d;
            word_q    <= word_d;
            result_q  <= result_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign Busy   = busy_q;
    assign Done   = done_q;
    assign Result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_div_iter_radix2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_div_iter_radix2                                                         |
// | Scoreboard bench: arithmetic reference model, decoupled Done monitor.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_div_iter_radix2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        Start = 1'b0;
    logic        Flush = 1'b0;
    logic [63:0] A = '0;
    logic [63:0] B = '0;
    logic [1:0]  Funct3 = '0;
    logic        W64 = 1'b0;
    logic        Busy, Done;
    logic [63:0] Result;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_res[$];
    int          exp_cyc[$];
    logic [63:0] last_res = '0;
    logic [63:0] mon_res;
    int          mon_cyc;

    div_iter_radix2 #(.WIDTH(64)) dut (
        .clk(clk), .reset_n(reset_n), .Start(Start), .Flush(Flush),
        .A(A), .B(B), .Funct3(Funct3), .W64(W64),
        .Busy(Busy), .Done(Done), .Result(Result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at time %0t, required completion", $time);
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on the effective operands.
    function automatic void model(input logic [63:0] a, input logic [63:0] b, input logic [1:0] f,
                                  input logic w, output logic [63:0] res, output int lat);
        logic [63:0] q, r;
        bit sp;
        sp = 0;
        if (w) begin
            int sa, sbv;
            logic [31:0] a32, b32, q32, r32;
            a32 = a[31:0]; b32 = b[31:0]; sa = a32; sbv = b32;
            if (b32 == 0) begin q32 = '1; r32 = a32; sp = 1; end
            else if (!f[0] && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin q32 = a32; r32 = 0; sp = 1; end
            else if (!f[0]) begin q32 = 32'(sa / sbv); r32 = 32'(sa % sbv); end
            else begin q32 = a32 / b32; r32 = a32 % b32; end
            q = {{32{q32[31]}}, q32};
            r = {{32{r32[31]}}, r32};
        end else begin
            longint sa, sbv;
            sa = a; sbv = b;
            if (b == 0) begin q = '1; r = a; sp = 1; end
            else if (!f[0] && a == 64'h8000_0000_0000_0000 && b == '1) begin q = a; r = 0; sp = 1; end
            else if (!f[0]) begin q = 64'(sa / sbv); r = 64'(sa % sbv); end
            else begin q = a / b; r = a % b; end
        end
        res = f[1] ? r : q;
        lat = sp ? 2 : (w ? 34 : 66);
    endfunction

    function automatic logic [63:0] rnd_op();
        case ($urandom_range(0, 7))
            0: return 64'd0;
            1: return '1;
            2: return 64'h8000_0000_0000_0000;
            3: return {$urandom, 32'h8000_0000};
            4: return 64'($urandom_range(1, 50));
            5: return 64'(-longint'($urandom_range(1, 50)));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Called just after a falling edge; Start is held for exactly one cycle.
    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [1:0] f,
                         input logic w, input bit expect_it);
        logic [63:0] r;
        int lat;
        A = a; B = b; Funct3 = f; W64 = w; Start = 1'b1;
        if (expect_it) begin
            model(a, b, f, w, r, lat);
            exp_res.push_back(r);
            exp_cyc.push_back(cyc + lat);
        end
        @(negedge clk);
        Start = 1'b0;
        A = {$urandom, $urandom}; B = {$urandom, $urandom};
        Funct3 = 2'($urandom); W64 = 1'($urandom);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (exp_res.size() == 0 && !Busy && !Done) return;
        end
        checks++; errors++;
        $display("FAIL wait_idle: got %0d pending results after timeout, expected 0", exp_res.size());
        exp_res.delete(); exp_cyc.delete();
    endtask

    task automatic wait_done();
        for (int i = 0; i < 100; i++) begin
            if (Done) return;
            @(negedge clk);
        end
        checks++; errors++;
        $display("FAIL wait_done: got no Done within 100 cycles, expected Done");
    endtask

    always @(negedge clk) begin
        if (reset_n && Done) begin
            if (exp_res.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done: got Done=1 at cycle %0d, expected no Done", cyc);
            end else begin
                mon_res = exp_res.pop_front();
                mon_cyc = exp_cyc.pop_front();
                check("result", Result, mon_res);
                check("done_cycle", 64'(cyc), 64'(mon_cyc));
                last_res = mon_res;
            end
        end
    end

    initial begin
        int t0, bad;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(Busy), 64'd0);
        check("reset_done", 64'(Done), 64'd0);
        check("reset_result", Result, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        issue(64'd100, 64'd7, 2'b01, 1'b0, 1); wait_idle();
        issue(64'd100, 64'd7, 2'b11, 1'b0, 1); wait_idle();

        // Busy must stay high for the whole iteration window of a full-width op.
        t0 = cyc;
        issue(64'(-64'sd7), 64'd2, 2'b00, 1'b0, 1);
        bad = 0;
        while (cyc <= t0 + 65) begin
            if (!Busy) bad++;
            @(negedge clk);
        end
        check("busy_window_drops", 64'(bad), 64'd0);
        check("busy_done_at_end", {62'd0, Busy, Done}, 64'd1);
        wait_idle();

        issue(64'(-64'sd7), 64'd2, 2'b10, 1'b0, 1); wait_idle();
        issue(64'd7, 64'(-64'sd2), 2'b10, 1'b0, 1); wait_idle();
        issue(64'd5, 64'd0, 2'b01, 1'b0, 1); wait_idle();
        issue(64'd5, 64'd0, 2'b11, 1'b0, 1); wait_idle();
        issue('1, 64'd0, 2'b00, 1'b0, 1); wait_idle();
        issue(64'h8000_0000_0000_0000, '1, 2'b00, 1'b0, 1); wait_idle();
        issue(64'h8000_0000_0000_0000, '1, 2'b10, 1'b0, 1); wait_idle();
        issue(64'h0000_0000_8000_0000, '1, 2'b00, 1'b1, 1); wait_idle();
        issue(64'h1234_5678_FFFF_FFFE, 64'd2, 2'b01, 1'b1, 1); wait_idle();
        issue(64'hFFFF_FFFF_FFFF_FFF9, 64'd3, 2'b10, 1'b1, 1); wait_idle();

        // Flush mid-operation, then restart in the very next cycle.
        t0 = cyc;
        issue(64'd1000, 64'd3, 2'b01, 1'b0, 0);
        while (cyc < t0 + 10) @(negedge clk);
        Flush = 1'b1;
        @(negedge clk);
        Flush = 1'b0;
        check("flush_busy", 64'(Busy), 64'd0);
        check("flush_result_kept", Result, last_res);
        issue(64'd999, 64'd10, 2'b11, 1'b0, 1); wait_idle();

        // Flush and Start together accept nothing.
        Flush = 1'b1;
        issue(64'd50, 64'd5, 2'b01, 1'b0, 0);
        Flush = 1'b0;
        check("flush_start_busy", 64'(Busy), 64'd0);
        repeat (5) @(negedge clk);

        // Start pulses while busy are ignored.
        issue(64'd123456, 64'd789, 2'b01, 1'b0, 1);
        repeat (4) begin
            repeat (7) @(negedge clk);
            issue({$urandom, $urandom}, 64'd1, 2'($urandom), 1'($urandom), 0);
        end
        wait_idle();

        // Start accepted in the Done cycle itself.
        issue(64'd77, 64'd0, 2'b01, 1'b0, 1);
        wait_done();
        issue(64'(-64'sd100), 64'd9, 2'b10, 1'b1, 1); wait_idle();

        // Flush during Done does not suppress that pulse.
        issue(64'd81, 64'd9, 2'b01, 1'b1, 1);
        wait_done();
        Flush = 1'b1;
        @(negedge clk);
        Flush = 1'b0;
        check("flush_in_done_busy", 64'(Busy), 64'd0);
        wait_idle();

        // Asynchronous reset mid-operation.
        t0 = cyc;
        issue(64'd5000, 64'd7, 2'b01, 1'b0, 0);
        while (cyc < t0 + 20) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_busy", 64'(Busy), 64'd0);
        check("async_reset_done", 64'(Done), 64'd0);
        check("async_reset_result", Result, 64'd0);
        last_res = '0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (80) @(negedge clk);
        check("post_reset_busy", 64'(Busy), 64'd0);

        for (int i = 0; i < 40; i++) begin
            issue(rnd_op(), rnd_op(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1);
            wait_idle();
        end

        check("scoreboard_empty", 64'(exp_res.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
